mc_maindec: RTL and testbench
=============================

MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 Parameter MEM_HANDSHAKE, default 1; 1 = memory states wait on mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op  in  6  opcode field of the instruction register.
REQ-006 mem_ready  in  1  memory completed the current access this cycle.
REQ-007 mem_req  out  1  memory access requested.
REQ-008 iord  out  1  memory address source: 0 = PC, 1 = ALU result register.
REQ-009 irwrite, pcwrite  out  1 each  instruction-register load; unconditional PC load.
REQ-010 branch, bne  out  1 each  conditional PC load on equal; conditional PC load on not-equal.
REQ-011 regwrite, memtoreg, regdst  out  1 each  register-file write, write data from memory, destination rd.
REQ-012 memwrite  out  2  store size: 00 none, 01 word, 10 byte, 11 double.
REQ-013 memread, readtype  out  1, 3  load enable; readtype: 000 LW, 001 LWU, 010 LB, 011 LBU, 100 LD.
REQ-014 alusrca, alusrcb, pcsrc  out  1, 2, 2  ALU A (0 PC, 1 rs); ALU B (00 rt, 01 const 4, 10 sign-ext imm, 11 zero-ext imm); PC (00 ALU, 01 ALUOut, 10 jump target).
REQ-015 aluop  out  3  000 add, 001 and, 010 or, 011 slt, 100 dadd, 110 sub (compare), 111 funct-decoded.
REQ-016 illegal  out  1  pulse: unsupported opcode decoded.

Function
REQ-017 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP.
REQ-018 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00; irwrite and pcwrite=1 only when mem_ready; advance to DECODE on mem_ready, else hold.
REQ-019 DECODE: alusrca=0, alusrcb=10, aluop=000 (branch-target precompute); next state from op per REQ-020.
REQ-020 Decode map: RTYPE 000000 -> EXEC; LD 110111, LWU 100111, LW 100011, LBU 100100, LB 100000, SD 111111, SW 101011, SB 101000 -> MEMADR; ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000 -> IMMEX; BEQ 000100, BNE 000101 -> BRANCH; J 000010 -> JUMP.
REQ-021 XLEN=32: LD, SD, DADDI are unsupported.
REQ-022 Unsupported op in DECODE: illegal=1 for that single cycle, next state FETCH, no write strobes asserted.
REQ-023 MEMADR: alusrca=1, alusrcb=10, aluop=000; loads -> MEMRD, stores -> MEMWR.
REQ-024 MEMRD: mem_req=1, iord=1, memread=1, readtype per REQ-013; hold until mem_ready, then MEMWB.
REQ-025 MEMWB: regwrite=1, memtoreg=1, regdst=0, memread=1, readtype held; -> FETCH.
REQ-026 MEMWR: mem_req=1, iord=1, memwrite=01/10/11 for SW/SB/SD; hold until mem_ready, then FETCH.
REQ-027 memwrite SHALL be nonzero only while in MEMWR.
REQ-028 EXEC: alusrca=1, alusrcb=00, aluop=111; -> ALUWB. ALUWB: regwrite=1, regdst=1, memtoreg=0; -> FETCH.
REQ-029 IMMEX: alusrca=1; ADDI/SLTI/DADDI alusrcb=10; ANDI/ORI alusrcb=11; aluop 000/011/100/001/010 respectively; -> IMMWB. IMMWB: regwrite=1, regdst=0; -> FETCH.
REQ-030 BRANCH: alusrca=1, alusrcb=00, aluop=110, pcsrc=01, branch=1 (BEQ) or bne=1 (BNE); -> FETCH. JUMP: pcwrite=1, pcsrc=10; -> FETCH.
REQ-031 Latency, zero wait: R-type/imm 4, load 5, store 4, branch 3, jump 3 cycles; each wait cycle on mem_ready adds one.
REQ-032 Op is captured into an internal register on DECODE exit; later states decode the captured value, not live op.
REQ-033 Outputs not listed for a state SHALL be 0.

Reset
REQ-034 reset asserted: state=FETCH, captured op=000000, every output 0 (mem_req included) asynchronously.
REQ-035 Reset mid-access (MEMRD/MEMWR waiting): access abandoned, no regwrite/memwrite thereafter; first post-reset clock edge begins FETCH.

Structure
REQ-036 Shared package mc_pkg: state enum, opcode constants, aluop/readtype/memwrite/alusrcb/pcsrc encodings.
REQ-037 One sub-module, mc_opdecode: combinational op -> class (rtype/load/store/imm/branch/jump/illegal), size codes, aluop.

Verification
REQ-038 ADD (op 000000), mem_ready=1: FETCH,DECODE,EXEC,ALUWB; regwrite=1, regdst=1 in cycle 4 only.
REQ-039 LBU (100100), mem_ready low 2 cycles in MEMRD: 7 cycles total; readtype=011 held; regwrite+memtoreg one cycle.
REQ-040 SD (111111), XLEN=64: memwrite=11 only in MEMWR; XLEN=32: illegal=1 in DECODE, memwrite stays 00.
REQ-041 BNE (000101): 3 cycles; bne=1, pcsrc=01, aluop=110 in BRANCH; branch=0.
REQ-042 Reset asserted during MEMWR wait: outputs 0 same cycle; after release, mem_req=1, iord=0 in FETCH.
REQ-043 Op changed to 000010 during MEMADR of LW: LW flow completes unaffected.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle main decoder.
// States, opcodes, control-field codes and the decoded-op bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_IMMEX,
        S_IMMWB,
        S_BRANCH,
        S_JUMP
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RTYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_IMM,
        CLS_BRANCH,
        CLS_JUMP
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_DADD  = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [2:0] RT_LW  = 3'b000;
    localparam logic [2:0] RT_LWU = 3'b001;
    localparam logic [2:0] RT_LB  = 3'b010;
    localparam logic [2:0] RT_LBU = 3'b011;
    localparam logic [2:0] RT_LD  = 3'b100;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_BYTE = 2'b10;
    localparam logic [1:0] MW_DBL  = 2'b11;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        op_class_e  cls;
        logic       is_bne;
        logic [2:0] readtype;
        logic [1:0] memwrite;
        logic [2:0] aluop;
        logic [1:0] srcb;
    } op_info_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] memwrite;
        logic       memread;
        logic [2:0] readtype;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier: instruction class, access sizes and
// immediate-path ALU controls; 64-bit ops only exist at XLEN=64.
module mc_opdecode
    import mc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [5:0] op_i,
    output op_info_t   info_o
);

    localparam bit IS64 = (XLEN == 64);

    // Table lookup of the opcode; anything unlisted stays illegal
    always_comb begin
        info_o     = '0;
        info_o.cls = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE: info_o.cls = CLS_RTYPE;
            OP_LD: begin
                if (IS64) begin
                    info_o.cls      = CLS_LOAD;
                    info_o.readtype = RT_LD;
                end
            end
            OP_LWU: begin
                info_o.cls      = CLS_LOAD;
                info_o.readtype = RT_LWU;
            end
            OP_LW: begin
                info_o.cls      = CLS_LOAD;
                info_o.readtype = RT_LW;
            end
            OP_LBU: begin
                info_o.cls      = CLS_LOAD;
                info_o.readtype = RT_LBU;
            end
            OP_LB: begin
                info_o.cls      = CLS_LOAD;
                info_o.readtype = RT_LB;
            end
            OP_SD: begin
                if (IS64) begin
                    info_o.cls      = CLS_STORE;
                    info_o.memwrite = MW_DBL;
                end
            end
            OP_SW: begin
                info_o.cls      = CLS_STORE;
                info_o.memwrite = MW_WORD;
            end
            OP_SB: begin
                info_o.cls      = CLS_STORE;
                info_o.memwrite = MW_BYTE;
            end
            OP_ADDI: begin
                info_o.cls   = CLS_IMM;
                info_o.aluop = ALU_ADD;
                info_o.srcb  = SRCB_SEXT;
            end
            OP_ANDI: begin
                info_o.cls   = CLS_IMM;
                info_o.aluop = ALU_AND;
                info_o.srcb  = SRCB_ZEXT;
            end
            OP_ORI: begin
                info_o.cls   = CLS_IMM;
                info_o.aluop = ALU_OR;
                info_o.srcb  = SRCB_ZEXT;
            end
            OP_SLTI: begin
                info_o.cls   = CLS_IMM;
                info_o.aluop = ALU_SLT;
                info_o.srcb  = SRCB_SEXT;
            end
            OP_DADDI: begin
                if (IS64) begin
                    info_o.cls   = CLS_IMM;
                    info_o.aluop = ALU_DADD;
                    info_o.srcb  = SRCB_SEXT;
                end
            end
            OP_BEQ: info_o.cls = CLS_BRANCH;
            OP_BNE: begin
                info_o.cls    = CLS_BRANCH;
                info_o.is_bne = 1'b1;
            end
            OP_J:    info_o.cls = CLS_JUMP;
            default: info_o.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps for a single-memory datapath.
module mc_maindec
    import mc_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] memwrite,
    output logic       memread,
    output logic [2:0] readtype,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    op_info_t   info;
    ctl_t       ctl;
    ctl_t       ctl_out;
    logic       rdy;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Live op is used while decoding; later states see the capture
    assign op_d = (state_q == S_DECODE) ? op : op_q;

    mc_opdecode #(
        .XLEN(XLEN)
    ) u_opdecode (
        .op_i  (op_d),
        .info_o(info)
    );

    // State and captured-opcode registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next state and per-state control outputs
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                ctl.mem_req = 1'b1;
                ctl.alusrcb = SRCB_FOUR;
                if (rdy) begin
                    ctl.irwrite = 1'b1;
                    ctl.pcwrite = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alusrcb = SRCB_SEXT;
                unique case (info.cls)
                    CLS_RTYPE:  state_d = S_EXEC;
                    CLS_LOAD:   state_d = S_MEMADR;
                    CLS_STORE:  state_d = S_MEMADR;
                    CLS_IMM:    state_d = S_IMMEX;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_SEXT;
                if (info.cls == CLS_LOAD) begin
                    state_d = S_MEMRD;
                end else if (info.cls == CLS_STORE) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                ctl.mem_req  = 1'b1;
                ctl.iord     = 1'b1;
                ctl.memread  = 1'b1;
                ctl.readtype = info.readtype;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
                ctl.memread  = 1'b1;
                ctl.readtype = info.readtype;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                ctl.mem_req  = 1'b1;
                ctl.iord     = 1'b1;
                ctl.memwrite = info.memwrite;
                if (rdy) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_RT;
                ctl.aluop   = ALU_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_IMMEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = info.srcb;
                ctl.aluop   = info.aluop;
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                ctl.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_RT;
                ctl.aluop   = ALU_SUB;
                ctl.pcsrc   = PC_ALUOUT;
                ctl.branch  = ~info.is_bne;
                ctl.bne     = info.is_bne;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                ctl.pcwrite = 1'b1;
                ctl.pcsrc   = PC_JUMP;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset silences every strobe immediately, not at the next edge
    assign ctl_out = reset ? '0 : ctl;

    assign mem_req  = ctl_out.mem_req;
    assign iord     = ctl_out.iord;
    assign irwrite  = ctl_out.irwrite;
    assign pcwrite  = ctl_out.pcwrite;
    assign branch   = ctl_out.branch;
    assign bne      = ctl_out.bne;
    assign regwrite = ctl_out.regwrite;
    assign memtoreg = ctl_out.memtoreg;
    assign regdst   = ctl_out.regdst;
    assign memwrite = ctl_out.memwrite;
    assign memread  = ctl_out.memread;
    assign readtype = ctl_out.readtype;
    assign alusrca  = ctl_out.alusrca;
    assign alusrcb  = ctl_out.alusrcb;
    assign pcsrc    = ctl_out.pcsrc;
    assign aluop    = ctl_out.aluop;
    assign illegal  = ctl_out.illegal;

endmodule

// File: tb/tb_mc_maindec.sv
// Testbench for mc_maindec: per-instruction expected control
// sequences, random ops/waits, XLEN=64 handshaked and XLEN=32 no-handshake.
module tb_mc_maindec;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] memwrite;
        logic       memread;
        logic [2:0] readtype;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        out_t       exp;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst64, rdy64, rst32, rdy32;
    logic [5:0] op64, op32;
    out_t       act64, act32, e64, e32;
    bit         v64, v32;
    int         checks = 0;
    int         failures = 0;
    int         cyc64 = 0;
    int         cyc32 = 0;
    cyc_t       seq[$];

    logic       a_mreq, a_iord, a_irw, a_pcw, a_br, a_bne;
    logic       a_rw, a_m2r, a_rd, a_mr, a_sa, a_ill;
    logic [1:0] a_mw, a_sb, a_pc;
    logic [2:0] a_rt, a_alu;
    logic       b_mreq, b_iord, b_irw, b_pcw, b_br, b_bne;
    logic       b_rw, b_m2r, b_rd, b_mr, b_sa, b_ill;
    logic [1:0] b_mw, b_sb, b_pc;
    logic [2:0] b_rt, b_alu;

    mc_maindec #(.XLEN(64), .MEM_HANDSHAKE(1'b1)) dut64 (
        .clk(clk), .reset(rst64), .op(op64), .mem_ready(rdy64),
        .mem_req(a_mreq), .iord(a_iord), .irwrite(a_irw),
        .pcwrite(a_pcw), .branch(a_br), .bne(a_bne),
        .regwrite(a_rw), .memtoreg(a_m2r), .regdst(a_rd),
        .memwrite(a_mw), .memread(a_mr), .readtype(a_rt),
        .alusrca(a_sa), .alusrcb(a_sb), .pcsrc(a_pc),
        .aluop(a_alu), .illegal(a_ill)
    );

    mc_maindec #(.XLEN(32), .MEM_HANDSHAKE(1'b0)) dut32 (
        .clk(clk), .reset(rst32), .op(op32), .mem_ready(rdy32),
        .mem_req(b_mreq), .iord(b_iord), .irwrite(b_irw),
        .pcwrite(b_pcw), .branch(b_br), .bne(b_bne),
        .regwrite(b_rw), .memtoreg(b_m2r), .regdst(b_rd),
        .memwrite(b_mw), .memread(b_mr), .readtype(b_rt),
        .alusrca(b_sa), .alusrcb(b_sb), .pcsrc(b_pc),
        .aluop(b_alu), .illegal(b_ill)
    );

    assign act64 = {a_mreq, a_iord, a_irw, a_pcw, a_br, a_bne,
                    a_rw, a_m2r, a_rd, a_mw, a_mr, a_rt,
                    a_sa, a_sb, a_pc, a_alu, a_ill};
    assign act32 = {b_mreq, b_iord, b_irw, b_pcw, b_br, b_bne,
                    b_rw, b_m2r, b_rd, b_mw, b_mr, b_rt,
                    b_sa, b_sb, b_pc, b_alu, b_ill};

    // Single compare point, half a cycle after inputs settle
    always @(negedge clk) begin
        if (v64) begin
            checks++;
            cyc64++;
            if (act64 !== e64) begin
                failures++;
                $display("FAIL dut64 cyc=%0d op=%b got=%h exp=%h",
                         cyc64, op64, act64, e64);
            end
        end
        if (v32) begin
            checks++;
            cyc32++;
            if (act32 !== e32) begin
                failures++;
                $display("FAIL dut32 cyc=%0d op=%b got=%h exp=%h",
                         cyc32, op32, act32, e32);
            end
        end
    end

    // Instruction table: kind 0 illegal,1 R,2 load,3 store,4 imm,
    // 5 beq,6 bne,7 jump
    function automatic void classify(
        input  logic [5:0] o,
        input  bit         is64,
        output int         k,
        output logic [2:0] rt,
        output logic [1:0] mw,
        output logic [2:0] alu,
        output logic [1:0] sb
    );
        k = 0; rt = 3'b000; mw = 2'b00; alu = 3'b000; sb = 2'b00;
        case (o)
            6'b000000: k = 1;
            6'b110111: if (is64) begin k = 2; rt = 3'b100; end
            6'b100111: begin k = 2; rt = 3'b001; end
            6'b100011: begin k = 2; rt = 3'b000; end
            6'b100100: begin k = 2; rt = 3'b011; end
            6'b100000: begin k = 2; rt = 3'b010; end
            6'b111111: if (is64) begin k = 3; mw = 2'b11; end
            6'b101011: begin k = 3; mw = 2'b01; end
            6'b101000: begin k = 3; mw = 2'b10; end
            6'b001000: begin k = 4; alu = 3'b000; sb = 2'b10; end
            6'b001100: begin k = 4; alu = 3'b001; sb = 2'b11; end
            6'b001101: begin k = 4; alu = 3'b010; sb = 2'b11; end
            6'b001010: begin k = 4; alu = 3'b011; sb = 2'b10; end
            6'b011000: if (is64) begin
                k = 4; alu = 3'b100; sb = 2'b10;
            end
            6'b000100: k = 5;
            6'b000101: k = 6;
            6'b000010: k = 7;
            default: k = 0;
        endcase
    endfunction

    function automatic logic [5:0] fop(input int fill);
        logic [5:0] r;
        r = (fill < 0) ? 6'($urandom) : 6'(fill);
        return r;
    endfunction

    task automatic add(input logic [5:0] o, input logic r,
                       input out_t e);
        cyc_t c;
        c.rst = 1'b0; c.op = o; c.rdy = r; c.exp = e;
        seq.push_back(c);
    endtask

    task automatic add_rst(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.rst = 1'b1; c.op = 6'($urandom);
            c.rdy = 1'($urandom); c.exp = '0;
            seq.push_back(c);
        end
    endtask

    // Memory phase: w stalled cycles then completion (no stall
    // when the handshake is ignored)
    task automatic addmem(input int w, input bit hs, input out_t ew,
                          input out_t ed, input int fill);
        if (hs) begin
            for (int i = 0; i < w; i++) add(fop(fill), 1'b0, ew);
            add(fop(fill), 1'b1, ed);
        end else begin
            add(fop(fill), 1'($urandom), ed);
        end
    endtask

    // Expected control sequence for one whole instruction
    task automatic gen(input logic [5:0] o, input bit is64,
                       input bit hs, input int fw, input int mw,
                       input int fill);
        int k;
        logic [2:0] rt, alu;
        logic [1:0] mwc, sb;
        out_t e, e2;
        classify(o, is64, k, rt, mwc, alu, sb);
        e = '0; e.mem_req = 1'b1; e.alusrcb = 2'b01;
        e2 = e; e2.irwrite = 1'b1; e2.pcwrite = 1'b1;
        addmem(fw, hs, e, e2, fill);
        e = '0; e.alusrcb = 2'b10; e.illegal = (k == 0);
        add(o, 1'($urandom), e);
        if (k == 0) return;
        e = '0;
        case (k)
            1: begin
                e.alusrca = 1'b1; e.aluop = 3'b111;
                add(fop(fill), 1'($urandom), e);
                e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
                add(fop(fill), 1'($urandom), e);
            end
            2: begin
                e.alusrca = 1'b1; e.alusrcb = 2'b10;
                add(fop(fill), 1'($urandom), e);
                e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
                e.memread = 1'b1; e.readtype = rt;
                addmem(mw, hs, e, e, fill);
                e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
                e.memread = 1'b1; e.readtype = rt;
                add(fop(fill), 1'($urandom), e);
            end
            3: begin
                e.alusrca = 1'b1; e.alusrcb = 2'b10;
                add(fop(fill), 1'($urandom), e);
                e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
                e.memwrite = mwc;
                addmem(mw, hs, e, e, fill);
            end
            4: begin
                e.alusrca = 1'b1; e.alusrcb = sb; e.aluop = alu;
                add(fop(fill), 1'($urandom), e);
                e = '0; e.regwrite = 1'b1;
                add(fop(fill), 1'($urandom), e);
            end
            5, 6: begin
                e.alusrca = 1'b1; e.aluop = 3'b110; e.pcsrc = 2'b01;
                e.branch = (k == 5); e.bne = (k == 6);
                add(fop(fill), 1'($urandom), e);
            end
            default: begin
                e.pcwrite = 1'b1; e.pcsrc = 2'b10;
                add(fop(fill), 1'($urandom), e);
            end
        endcase
    endtask

    // Apply the queued cycles to one DUT back to back
    task automatic run(input bit sel);
        foreach (seq[i]) begin
            @(posedge clk);
            #1;
            if (!sel) begin
                rst64 = seq[i].rst; op64 = seq[i].op;
                rdy64 = seq[i].rdy; e64 = seq[i].exp; v64 = 1'b1;
            end else begin
                rst32 = seq[i].rst; op32 = seq[i].op;
                rdy32 = seq[i].rdy; e32 = seq[i].exp; v32 = 1'b1;
            end
        end
        seq.delete();
    endtask

    task automatic pin(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL pin_%s got=%0d exp=%0d", n, got, want);
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] t [17];
        t = '{6'b000000, 6'b110111, 6'b100111, 6'b100011, 6'b100100,
              6'b100000, 6'b111111, 6'b101011, 6'b101000, 6'b001000,
              6'b001100, 6'b001101, 6'b001010, 6'b011000, 6'b000100,
              6'b000101, 6'b000010};
        if ($urandom_range(0, 3) == 0) return 6'($urandom);
        return t[$urandom_range(0, 16)];
    endfunction

    initial begin
        rst64 = 1'b1; rst32 = 1'b1; op64 = '0; op32 = '0;
        rdy64 = 1'b0; rdy32 = 1'b0; v64 = 1'b0; v32 = 1'b0;
        e64 = '0; e32 = '0;

        gen(6'b000000, 1'b1, 1'b1, 0, 0, -1);
        pin("add_len", seq.size(), 4);
        pin("add_wb", {seq[3].exp.regwrite, seq[3].exp.regdst}, 3);
        pin("add_exec_rw", seq[2].exp.regwrite, 0);
        seq.delete();
        gen(6'b100100, 1'b1, 1'b1, 0, 2, -1);
        pin("lbu_len", seq.size(), 7);
        pin("lbu_rt", seq[3].exp.readtype, 3);
        pin("lbu_wb", {seq[6].exp.regwrite, seq[6].exp.memtoreg}, 3);
        seq.delete();
        gen(6'b111111, 1'b1, 1'b1, 0, 0, -1);
        pin("sd64_len", seq.size(), 4);
        pin("sd64_mw", seq[3].exp.memwrite, 3);
        pin("sd64_adr_mw", seq[2].exp.memwrite, 0);
        seq.delete();
        gen(6'b111111, 1'b0, 1'b1, 0, 0, -1);
        pin("sd32_len", seq.size(), 2);
        pin("sd32_ill", seq[1].exp.illegal, 1);
        seq.delete();
        gen(6'b000101, 1'b1, 1'b1, 0, 0, -1);
        pin("bne_len", seq.size(), 3);
        pin("bne_ctl", {seq[2].exp.bne, seq[2].exp.branch,
                        seq[2].exp.pcsrc, seq[2].exp.aluop}, 'b10_01_110);
        seq.delete();
        gen(6'b000010, 1'b1, 1'b1, 0, 0, -1);
        pin("j_len", seq.size(), 3);
        seq.delete();

        add_rst(2);
        gen(6'b000000, 1'b1, 1'b1, 0, 0, -1);
        gen(6'b100100, 1'b1, 1'b1, 0, 2, -1);
        gen(6'b111111, 1'b1, 1'b1, 1, 1, -1);
        gen(6'b000101, 1'b1, 1'b1, 0, 0, -1);
        gen(6'b100011, 1'b1, 1'b1, 0, 1, 2);
        run(1'b0);

        gen(6'b111111, 1'b1, 1'b1, 0, 4, -1);
        void'(seq.pop_back());
        void'(seq.pop_back());
        add_rst(2);
        gen(6'b101011, 1'b1, 1'b1, 0, 0, -1);
        gen(6'b100000, 1'b1, 1'b1, 0, 3, -1);
        void'(seq.pop_back());
        void'(seq.pop_back());
        add_rst(1);
        gen(6'b001100, 1'b1, 1'b1, 0, 0, -1);
        run(1'b0);

        for (int n = 0; n < 250; n++) begin
            gen(rand_op(), 1'b1, 1'b1, $urandom_range(0, 2),
                $urandom_range(0, 2), -1);
            run(1'b0);
        end
        @(posedge clk);
        #1;
        v64 = 1'b0; rst64 = 1'b1;

        add_rst(2);
        gen(6'b111111, 1'b0, 1'b0, 0, 0, -1);
        gen(6'b110111, 1'b0, 1'b0, 0, 0, -1);
        gen(6'b011000, 1'b0, 1'b0, 0, 0, -1);
        gen(6'b100111, 1'b0, 1'b0, 0, 0, -1);
        run(1'b1);
        for (int n = 0; n < 150; n++) begin
            gen(rand_op(), 1'b0, 1'b0, 0, 0, -1);
            run(1'b1);
        end
        @(posedge clk);
        #1;
        v32 = 1'b0; rst32 = 1'b1;
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
